// File: rtl/add_sequencer.sv
// Sequencer for a 4-bit combinational ripple adder: takes operand pairs, holds them
// on the adder for SETTLE cycles, returns the captured sum, and keeps a running total.
module add_sequencer #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    input  logic [4:0] add_s,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_sum,
    input  logic       acc_clr,
    output logic [7:0] acc_total
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned SUM_W = 5;
    localparam int unsigned ACC_W = 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   add_a_d, add_b_d;
    logic [SUM_W-1:0]  out_sum_d;
    logic              out_valid_d;
    logic [ACC_W-1:0]  acc_total_d;
    logic              out_xfer;

    assign in_ready = (state_q == ST_IDLE);
    assign out_xfer = out_valid && out_ready;

    // Next-state, operand capture, sum capture and accumulator update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a;
        add_b_d     = add_b;
        out_sum_d   = out_sum;
        out_valid_d = out_valid;
        acc_total_d = acc_total;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    add_a_d = in_a;
                    add_b_d = in_b;
                    cnt_d   = CNT_W'(SETTLE - 1);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    out_sum_d   = add_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear takes priority, then the delivered sum is folded in
        if (acc_clr) begin
            acc_total_d = out_xfer ? ACC_W'(out_sum) : '0;
        end else if (out_xfer) begin
            acc_total_d = acc_total + ACC_W'(out_sum);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            add_a     <= '0;
            add_b     <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
            acc_total <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            add_a     <= add_a_d;
            add_b     <= add_b_d;
            out_sum   <= out_sum_d;
            out_valid <= out_valid_d;
            acc_total <= acc_total_d;
        end
    end

endmodule

// File: tb/tb_add_sequencer.sv
// Directed bench for add_sequencer: SETTLE=2 instance with an ideal adder, plus
// SETTLE=1 and SETTLE=15 instances whose adder model is invalid until settled.
module tb_add_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready, acc_clr;
    logic [3:0] in_a, in_b, add_a, add_b;
    logic [4:0] add_s, out_sum;
    logic [7:0] acc_total;
    logic [4:0] s;
    int         checks = 0;
    int         errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    add_sequencer #(.SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .acc_clr(acc_clr), .acc_total(acc_total)
    );

    assign add_s = {1'b0, add_a} + {1'b0, add_b};

    // Latency instances: index 0 is SETTLE=1, index 1 is SETTLE=15
    logic       l_in_valid [2];
    logic       l_in_ready [2];
    logic       l_out_valid[2];
    logic       l_out_ready[2];
    logic       l_acc_clr  [2];
    logic [3:0] l_in_a     [2];
    logic [3:0] l_in_b     [2];
    logic [3:0] l_add_a    [2];
    logic [3:0] l_add_b    [2];
    logic [4:0] l_add_s    [2];
    logic [4:0] l_out_sum  [2];
    logic [7:0] l_acc_total[2];

    for (genvar k = 0; k < 2; k++) begin : g_lat
        localparam int unsigned S = (k == 0) ? 1 : 15;
        int         age  = 100;
        logic [7:0] prev = 8'h00;

        add_sequencer #(.SETTLE(S)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(l_in_valid[k]), .in_ready(l_in_ready[k]),
            .in_a(l_in_a[k]), .in_b(l_in_b[k]),
            .add_a(l_add_a[k]), .add_b(l_add_b[k]), .add_s(l_add_s[k]),
            .out_valid(l_out_valid[k]), .out_ready(l_out_ready[k]),
            .out_sum(l_out_sum[k]),
            .acc_clr(l_acc_clr[k]), .acc_total(l_acc_total[k])
        );

        // Adder output is the impossible value 31 until S half-cycles-after-change negedges pass
        assign l_add_s[k] = (age >= int'(S)) ? ({1'b0, l_add_a[k]} + {1'b0, l_add_b[k]}) : 5'd31;

        always @(negedge clk) begin
            if ({l_add_a[k], l_add_b[k]} != prev) age = 1;
            else if (age < 100) age = age + 1;
            prev = {l_add_a[k], l_add_b[k]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One full operation on the SETTLE=2 instance; clr is applied with the output handshake
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic clr,
                         output logic [4:0] sum);
        int n;
        n = 0;
        in_a = a; in_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("op_done", 32'(out_valid), 1);
        sum = out_sum;
        out_ready = 1'b1; acc_clr = clr;
        @(negedge clk);
        out_ready = 1'b0; acc_clr = 1'b0;
    endtask

    task automatic lat(input int k, input int exp_lat, input logic [3:0] a, input logic [3:0] b);
        int n;
        n = 0;
        l_in_a[k] = a; l_in_b[k] = b; l_in_valid[k] = 1'b1;
        @(negedge clk);
        l_in_valid[k] = 1'b0;
        while (!l_out_valid[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_lat);
        chk("lat_sum", 32'(l_out_sum[k]), 32'({1'b0, a} + {1'b0, b}));
        l_out_ready[k] = 1'b1;
        @(negedge clk);
        l_out_ready[k] = 1'b0;
        chk("lat_idle", 32'(l_in_ready[k]), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b0; in_a = '0; in_b = '0;
        for (int k = 0; k < 2; k++) begin
            l_in_valid[k] = 1'b0; l_out_ready[k] = 1'b0; l_acc_clr[k] = 1'b0;
            l_in_a[k] = '0; l_in_b[k] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_add_a", 32'(add_a), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_acc", 32'(acc_total), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add 11+3, latency 2
        in_a = 4'b1011; in_b = 4'b0011; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("b_in_ready", 32'(in_ready), 0);
        chk("b_add_a", 32'(add_a), 11);
        chk("b_add_b", 32'(add_b), 3);
        @(negedge clk);
        chk("b_early", 32'(out_valid), 0);
        @(negedge clk);
        chk("b_valid", 32'(out_valid), 1);
        chk("b_sum", 32'(out_sum), 14);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("b_acc", 32'(acc_total), 14);
        chk("b_ready_back", 32'(in_ready), 1);

        // Carry 15+15 with in_valid pulses ignored during SETTLE
        in_a = 4'd15; in_b = 4'd15; in_valid = 1'b1;
        @(negedge clk);
        chk("c_in_ready0", 32'(in_ready), 0);
        in_a = 4'd1; in_b = 4'd1;
        @(negedge clk);
        chk("c_in_ready1", 32'(in_ready), 0);
        chk("c_add_a", 32'(add_a), 15);
        chk("c_add_b", 32'(add_b), 15);
        @(negedge clk);
        chk("c_valid", 32'(out_valid), 1);
        chk("c_sum", 32'(out_sum), 30);
        chk("c_carry", 32'(out_sum[4]), 1);
        chk("c_in_ready2", 32'(in_ready), 0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("c_acc", 32'(acc_total), 44);
        chk("c_idle", 32'(in_ready), 1);
        chk("c_keep_a", 32'(add_a), 15);

        // Backpressure 7+6 with a competing offer of 2+2
        in_a = 4'd7; in_b = 4'd6; in_valid = 1'b1;
        @(negedge clk);
        in_a = 4'd2; in_b = 4'd2;
        @(negedge clk);
        @(negedge clk);
        chk("p_valid", 32'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("p_sum", 32'(out_sum), 13);
            chk("p_add_a", 32'(add_a), 7);
            chk("p_add_b", 32'(add_b), 6);
            chk("p_hold", 32'(out_valid), 1);
            chk("p_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("p_acc", 32'(acc_total), 57);
        chk("p_idle", 32'(in_ready), 1);
        chk("p_not_taken", 32'(add_a), 7);
        @(negedge clk);
        in_valid = 1'b0;
        chk("p_taken_a", 32'(add_a), 2);
        chk("p_taken_b", 32'(add_b), 2);
        chk("p_busy", 32'(in_ready), 0);
        @(negedge clk);
        @(negedge clk);
        chk("p2_sum", 32'(out_sum), 4);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("p2_acc", 32'(acc_total), 61);

        // Clear alone, then out_ready while idle has no effect
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        chk("clr_alone", 32'(acc_total), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_ready_acc", 32'(acc_total), 0);
        chk("idle_ready_state", 32'(in_ready), 1);

        // Wrap: nine 15+15 -> 270 mod 256 = 14, then clear-with-transfer of 3+4
        for (int i = 0; i < 9; i++) do_op(4'd15, 4'd15, 1'b0, s);
        chk("wrap_acc", 32'(acc_total), 14);
        do_op(4'd3, 4'd4, 1'b1, s);
        chk("clr_xfer_sum", 32'(s), 7);
        chk("clr_xfer_acc", 32'(acc_total), 7);

        // Reset during SETTLE with 9+9 in flight
        in_a = 4'd9; in_b = 4'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_in_ready", 32'(in_ready), 1);
        chk("mr_add_a", 32'(add_a), 0);
        chk("mr_add_b", 32'(add_b), 0);
        chk("mr_acc", 32'(acc_total), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mr_no_result", 32'(out_valid), 0);
        end

        // Latency on SETTLE=1 and SETTLE=15 builds
        lat(0, 1, 4'd5, 4'd9);
        lat(0, 1, 4'd15, 4'd14);
        lat(1, 15, 4'd6, 4'd7);
        lat(1, 15, 4'd12, 4'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
